// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
// Define PIPE_FWD_EN to compile in operand forwarding; otherwise every RAW match stalls ID.

module pipe_hazard_src (
  input  logic [4:0]      rs,
  input  logic            use_rs,
  input  logic [2:0][4:0] rd_st,   // index 0 = DE, 1 = EM, 2 = MW
  input  logic [2:0]      we_st,
  input  logic [1:0]      ld_st,   // MW load data is already back, so only DE/EM matter
  input  logic [2:0]      vld_st,
  output logic            stall,
  output logic [1:0]      fwd_sel
);
  logic [2:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++)
      hit[i] = use_rs && (rs != 5'd0) && vld_st[i] && we_st[i] && (rd_st[i] == rs);
  end

`ifdef PIPE_FWD_EN
  // Nearest producer wins; a load still in DE/EM has no data to forward yet.
  always_comb begin
    stall   = 1'b0;
    fwd_sel = 2'd0;
    if (hit[0]) begin
      if (ld_st[0]) stall = 1'b1;
      else          fwd_sel = 2'd1;
    end else if (hit[1]) begin
      if (ld_st[1]) stall = 1'b1;
      else          fwd_sel = 2'd2;
    end else if (hit[2]) begin
      fwd_sel = 2'd3;
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_st;
  assign stall     = |hit;
  assign fwd_sel   = 2'd0;
`endif
endmodule

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic [4:0]       RD_ID,
  input  logic             WE_ID,
  input  logic             LOAD_ID,
  input  logic             REDIRECT,
  input  logic             MEM_WAIT,
  output logic             EN_PC,
  output logic             EN_FD,
  output logic             EN_DE,
  output logic             EN_EM,
  output logic             EN_MW,
  output logic             PC_SEL,
  output logic             FLUSH_FD,
  output logic             BUBBLE_DE,
  output logic             VALID_DE,
  output logic             VALID_EM,
  output logic             VALID_MW,
  output logic [1:0]       FWD1_SEL,
  output logic [1:0]       FWD2_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       load;
  } stg_t;

  logic [3:0]      vld_pipe;   // 0 = FD, 1 = DE, 2 = EM, 3 = MW
  stg_t            de_q, em_q, mw_q;
  logic [2:0][4:0] rd_st;
  logic [2:0]      we_st;
  logic [1:0]      ld_st;
  logic [1:0][4:0] rs_v;
  logic [1:0]      use_v;
  logic [1:0]      src_stall;
  logic [1:0][1:0] src_fwd;
  logic            redir, hazard;

  assign rd_st = {mw_q.rd, em_q.rd, de_q.rd};
  assign we_st = {mw_q.we, em_q.we, de_q.we};
  assign ld_st = {em_q.load, de_q.load};
  assign rs_v  = {RS2_ID, RS1_ID};
  assign use_v = {USE_RS2_ID, USE_RS1_ID};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_src
      pipe_hazard_src u_src (
        .rs      (rs_v[g]),
        .use_rs  (use_v[g]),
        .rd_st   (rd_st),
        .we_st   (we_st),
        .ld_st   (ld_st),
        .vld_st  (vld_pipe[3:1]),
        .stall   (src_stall[g]),
        .fwd_sel (src_fwd[g])
      );
    end
  endgenerate

  // Redirect outranks a hazard: the stalled ID instruction is on the wrong path anyway.
  assign redir  = !RST && !MEM_WAIT && REDIRECT && vld_pipe[1];
  assign hazard = !RST && !MEM_WAIT && !redir && (|src_stall);

  always_comb begin
    EN_PC     = 1'b0;
    EN_FD     = 1'b0;
    EN_DE     = 1'b0;
    EN_EM     = 1'b0;
    EN_MW     = 1'b0;
    PC_SEL    = 1'b0;
    FLUSH_FD  = 1'b0;
    BUBBLE_DE = 1'b0;
    if (!RST && !MEM_WAIT) begin
      EN_DE = 1'b1;
      EN_EM = 1'b1;
      EN_MW = 1'b1;
      if (redir) begin
        EN_PC     = 1'b1;
        EN_FD     = 1'b1;
        PC_SEL    = 1'b1;
        FLUSH_FD  = 1'b1;
        BUBBLE_DE = 1'b1;
      end else if (hazard) begin
        BUBBLE_DE = 1'b1;
      end else begin
        EN_PC = 1'b1;
        EN_FD = 1'b1;
      end
    end
  end

  assign FWD1_SEL = RST ? 2'd0 : src_fwd[0];
  assign FWD2_SEL = RST ? 2'd0 : src_fwd[1];
  assign VALID_DE = vld_pipe[1];
  assign VALID_EM = vld_pipe[2];
  assign VALID_MW = vld_pipe[3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe  <= '0;
      de_q      <= '0;
      em_q      <= '0;
      mw_q      <= '0;
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (EN_FD) vld_pipe[0] <= ~FLUSH_FD;
      if (EN_DE) begin
        vld_pipe[1] <= vld_pipe[0] & ~BUBBLE_DE;
        de_q        <= BUBBLE_DE ? '0 : stg_t'{rd: RD_ID, we: WE_ID, load: LOAD_ID};
      end
      if (EN_EM) begin
        vld_pipe[2] <= vld_pipe[1];
        em_q        <= de_q;
      end
      if (EN_MW) begin
        vld_pipe[3] <= vld_pipe[2];
        mw_q        <= em_q;
      end
      if (hazard && (STALL_CNT != {CNT_W{1'b1}})) STALL_CNT <= STALL_CNT + CNT_W'(1);
      if (redir  && (FLUSH_CNT != {CNT_W{1'b1}})) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against an in-flight instruction queue model.
// Honors PIPE_FWD_EN the same way as the design; counters are narrowed to reach saturation.

module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ins_t;

  typedef enum int {M_FREEZE, M_REDIR, M_STALL, M_NORM} mode_t;

  logic CLK = 1'b0, RST = 1'b1;
  logic [4:0] RS1_ID = '0, RS2_ID = '0, RD_ID = '0;
  logic USE_RS1_ID = 0, USE_RS2_ID = 0, WE_ID = 0, LOAD_ID = 0, REDIRECT = 0, MEM_WAIT = 0;
  logic EN_PC, EN_FD, EN_DE, EN_EM, EN_MW, PC_SEL, FLUSH_FD, BUBBLE_DE;
  logic VALID_DE, VALID_EM, VALID_MW;
  logic [1:0] FWD1_SEL, FWD2_SEL;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID), .RD_ID(RD_ID), .WE_ID(WE_ID),
    .LOAD_ID(LOAD_ID), .REDIRECT(REDIRECT), .MEM_WAIT(MEM_WAIT),
    .EN_PC(EN_PC), .EN_FD(EN_FD), .EN_DE(EN_DE), .EN_EM(EN_EM), .EN_MW(EN_MW),
    .PC_SEL(PC_SEL), .FLUSH_FD(FLUSH_FD), .BUBBLE_DE(BUBBLE_DE),
    .VALID_DE(VALID_DE), .VALID_EM(VALID_EM), .VALID_MW(VALID_MW),
    .FWD1_SEL(FWD1_SEL), .FWD2_SEL(FWD2_SEL), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
  localparam int B2B_STALLS = 0, LOAD_STALLS = 2;
`else
  localparam bit FWD = 1'b0;
  localparam int B2B_STALLS = 3, LOAD_STALLS = 3;
`endif

  int   n_vec = 0, n_err = 0;
  logic fd_v;
  ins_t q[$];           // q[0] = DE, q[1] = EM, q[2] = MW
  int   scnt, fcnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fd_v = 1'b0;
    q = {};
    repeat (3) q.push_back('0);
    scnt = 0;
    fcnt = 0;
  endtask

  // Nearest in-flight producer of rs decides stall/forward.
  function automatic void src_eval(input logic [4:0] rs, input logic u,
                                   output logic st, output logic [1:0] fs);
    st = 1'b0;
    fs = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (u && rs != 0 && q[i].v && q[i].we && q[i].rd == rs) begin
        if (!FWD || (i < 2 && q[i].ld)) st = 1'b1;
        else fs = 2'(i + 1);
        break;
      end
    end
  endfunction

  task automatic step(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic rdr, input logic mw, output logic obs_stall);
    logic st1, st2;
    logic [1:0] f1, f2;
    logic [7:0] exp_ctrl;
    mode_t m;
    ins_t nd;
    RS1_ID = rs1; USE_RS1_ID = u1; RS2_ID = rs2; USE_RS2_ID = u2;
    RD_ID = rd; WE_ID = we; LOAD_ID = ld; REDIRECT = rdr; MEM_WAIT = mw;
    @(negedge CLK);
    src_eval(rs1, u1, st1, f1);
    src_eval(rs2, u2, st2, f2);
    if (mw)               m = M_FREEZE;
    else if (rdr && q[0].v) m = M_REDIR;
    else if (st1 || st2)  m = M_STALL;
    else                  m = M_NORM;
    case (m)
      M_FREEZE: exp_ctrl = 8'b0000_0000;
      M_REDIR:  exp_ctrl = 8'b1111_1111;
      M_STALL:  exp_ctrl = 8'b0011_1001;
      default:  exp_ctrl = 8'b1111_1000;
    endcase
    chk("ctrl", {EN_PC, EN_FD, EN_DE, EN_EM, EN_MW, PC_SEL, FLUSH_FD, BUBBLE_DE}, exp_ctrl);
    if (!FWD || m == M_NORM) begin
      chk("fwd1", FWD1_SEL, FWD ? f1 : 2'd0);
      chk("fwd2", FWD2_SEL, FWD ? f2 : 2'd0);
    end
    chk("valid", {VALID_DE, VALID_EM, VALID_MW}, {q[0].v, q[1].v, q[2].v});
    chk("stall_cnt", STALL_CNT, scnt);
    chk("flush_cnt", FLUSH_CNT, fcnt);
    obs_stall = !EN_PC && !mw;
    if (m != M_FREEZE) begin
      nd = (m == M_NORM) ? ins_t'{v: fd_v, rd: rd, we: we, ld: ld} : ins_t'('0);
      q.push_front(nd);
      void'(q.pop_back());
      if (m == M_REDIR) begin
        fd_v = 1'b0;
        if (fcnt < CMAX) fcnt++;
      end else if (m == M_STALL) begin
        if (scnt < CMAX) scnt++;
      end else begin
        fd_v = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic nops(input int n);
    logic s;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask

  // Producer then a consumer of the same register, consumer held in ID until it advances.
  task automatic dep_pair(input string tag, input logic [4:0] r, input logic ld, input int exp_st);
    logic s;
    int   n = 0;
    bit   done = 0;
    step(0, 0, 0, 0, r, 1, ld, 0, 0, s);
    for (int k = 0; k < 8 && !done; k++) begin
      step(r, 1, 0, 0, 5'd7, 1, 0, 0, 0, s);
      if (s) n++;
      else done = 1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk(tag, n, exp_st);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {EN_PC, EN_FD, EN_DE, EN_EM, EN_MW, PC_SEL, FLUSH_FD, BUBBLE_DE}, 0);
    chk({tag, "_fwd"}, {FWD1_SEL, FWD2_SEL}, 0);
    chk({tag, "_valid"}, {VALID_DE, VALID_EM, VALID_MW}, 0);
    chk({tag, "_cnt"}, {STALL_CNT, FLUSH_CNT}, 0);
  endtask

  initial begin
    logic s;
    model_reset();
    MEM_WAIT = 1'b1;
    REDIRECT = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 5'(8 + i), 1, 0, 0, 0, s);
    chk("mw_after_adds", VALID_MW, 1);
    chk("no_stall_adds", STALL_CNT, 0);
    dep_pair("b2b_stalls", 5'd5, 1'b0, B2B_STALLS);
    nops(4);
    dep_pair("load_use_stalls", 5'd6, 1'b1, LOAD_STALLS);
    nops(4);
    dep_pair("x0_stalls", 5'd0, 1'b0, 0);
    nops(4);

    // Hold MEM_WAIT with a pending redirect, then let it through.
    step(0, 0, 0, 0, 5'd9, 1, 0, 0, 0, s);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 1, s);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, s);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        RST = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
      end
      step(5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 5),
           5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 6) == 0), s);
    end
    chk("stall_sat", STALL_CNT, CMAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
